// File: rtl/game_event_ctrl.sv
// Session-flow controller for the avoid-it game.
// Sequences start, lives, multi-stage progression, the hit pause, game over
// and win. Gates the game core, pulses a per-stage restart, and drives the
// LEDs, a saturating score and the LCD message code with its update strobe.
// Every output is registered and is computed from the next state, so it
// changes on the same edge as the state transition.
module game_event_ctrl #(
  parameter int TICK_DIV        = 1000,
  parameter int NUM_LIVES       = 3,
  parameter int NUM_STAGES      = 4,
  parameter int HIT_PAUSE_TICKS = 500,
  parameter int BLINK_TICKS     = 250,
  parameter int SCORE_W         = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_star,
  input  logic               collision_detected,
  input  logic               game_clear,
  output logic               run_game,
  output logic               stage_restart,
  output logic [3:0]         lives,
  output logic [3:0]         stage,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         msg_sel,
  output logic               msg_update,
  output logic               led_red,
  output logic               led_green
);

  // State codes equal the LCD message codes, so msg_sel is the next state.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RUN       = 3'd1;
  localparam logic [2:0] S_HIT       = 3'd2;
  localparam logic [2:0] S_STAGE_CLR = 3'd3;
  localparam logic [2:0] S_OVER      = 3'd4;
  localparam logic [2:0] S_WIN       = 3'd5;

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int PAUSE_W = $clog2(HIT_PAUSE_TICKS + 1);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(HIT_PAUSE_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
  localparam logic [3:0]         LIVES_INIT = 4'(NUM_LIVES);
  localparam logic [3:0]         STAGE_LAST = 4'(NUM_STAGES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  logic [2:0]         state_r;
  logic               key_star_q_r;
  logic [TICK_W-1:0]  tick_cnt_r;
  logic [PAUSE_W-1:0] pause_cnt_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_r;
  logic [3:0]         lives_r;
  logic [3:0]         stage_r;
  logic [SCORE_W-1:0] score_r;
  logic               run_game_r;
  logic               stage_restart_r;
  logic [2:0]         msg_sel_r;
  logic [2:0]         msg_sel_prev_r;
  logic               msg_update_r;
  logic               boot_r;
  logic               led_red_r;
  logic               led_green_r;

  logic               press_s;
  logic               counting_s;
  logic               blinking_s;
  logic               tick_s;
  logic               blink_toggle_s;
  logic               state_change_s;
  logic               blink_next_s;
  logic [2:0]         state_next_s;
  logic               restart_s;
  logic [3:0]         lives_next_s;
  logic [3:0]         stage_next_s;
  logic [SCORE_W-1:0] score_next_s;

  assign press_s        = key_star & ~key_star_q_r;
  assign counting_s     = (state_r == S_RUN) || (state_r == S_HIT) || (state_r == S_WIN);
  assign blinking_s     = (state_r == S_HIT) || (state_r == S_WIN);
  assign tick_s         = counting_s && (tick_cnt_r == TICK_LAST);
  assign blink_toggle_s = blinking_s && tick_s && (blink_cnt_r == BLINK_LAST);
  assign state_change_s = (state_next_s != state_r);

  // Next-state and session-variable decode; collision takes priority over clear.
  always_comb begin
    state_next_s = state_r;
    restart_s    = 1'b0;
    lives_next_s = lives_r;
    stage_next_s = stage_r;
    score_next_s = score_r;
    case (state_r)
      S_IDLE: begin
        if (press_s) begin
          state_next_s = S_RUN;
          restart_s    = 1'b1;
          lives_next_s = LIVES_INIT;
          stage_next_s = 4'd0;
          score_next_s = {SCORE_W{1'b0}};
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (tick_s && (score_r != SCORE_MAX)) begin
          score_next_s = score_r + SCORE_W'(1);
        end else begin
          score_next_s = score_r;
        end
        if (collision_detected) begin
          if (lives_r > 4'd1) begin
            lives_next_s = lives_r - 4'd1;
            state_next_s = S_HIT;
          end else begin
            lives_next_s = 4'd0;
            state_next_s = S_OVER;
          end
        end else if (game_clear) begin
          if (stage_r == STAGE_LAST) begin
            state_next_s = S_WIN;
          end else begin
            state_next_s = S_STAGE_CLR;
          end
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_HIT: begin
        if (tick_s && (pause_cnt_r == PAUSE_LAST)) begin
          state_next_s = S_RUN;
          restart_s    = 1'b1;
        end else begin
          state_next_s = S_HIT;
        end
      end
      S_STAGE_CLR: begin
        if (press_s) begin
          state_next_s = S_RUN;
          restart_s    = 1'b1;
          stage_next_s = stage_r + 4'd1;
        end else begin
          state_next_s = S_STAGE_CLR;
        end
      end
      S_OVER, S_WIN: begin
        if (press_s) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Blink phase restarts at 1 on every state entry and flips on each blink period.
  always_comb begin
    blink_next_s = blink_r;
    if (state_change_s) begin
      blink_next_s = 1'b1;
    end else if (blink_toggle_s) begin
      blink_next_s = ~blink_r;
    end else begin
      blink_next_s = blink_r;
    end
  end

  // State, timing counters and session variables.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      key_star_q_r <= 1'b0;
      tick_cnt_r   <= {TICK_W{1'b0}};
      pause_cnt_r  <= {PAUSE_W{1'b0}};
      blink_cnt_r  <= {BLINK_W{1'b0}};
      blink_r      <= 1'b0;
      lives_r      <= LIVES_INIT;
      stage_r      <= 4'd0;
      score_r      <= {SCORE_W{1'b0}};
    end else begin
      state_r      <= state_next_s;
      key_star_q_r <= key_star;
      lives_r      <= lives_next_s;
      stage_r      <= stage_next_s;
      score_r      <= score_next_s;
      blink_r      <= blink_next_s;
      if (state_change_s || !counting_s || tick_s) begin
        tick_cnt_r <= {TICK_W{1'b0}};
      end else begin
        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
      end
      if (state_change_s) begin
        pause_cnt_r <= {PAUSE_W{1'b0}};
      end else if ((state_r == S_HIT) && tick_s) begin
        pause_cnt_r <= pause_cnt_r + PAUSE_W'(1);
      end else begin
        pause_cnt_r <= pause_cnt_r;
      end
      if (state_change_s || blink_toggle_s) begin
        blink_cnt_r <= {BLINK_W{1'b0}};
      end else if (blinking_s && tick_s) begin
        blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      end else begin
        blink_cnt_r <= blink_cnt_r;
      end
    end
  end

  // Registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_game_r      <= 1'b0;
      stage_restart_r <= 1'b0;
      msg_sel_r       <= S_IDLE;
      led_red_r       <= 1'b0;
      led_green_r     <= 1'b0;
    end else begin
      run_game_r      <= (state_next_s == S_RUN);
      stage_restart_r <= restart_s;
      msg_sel_r       <= state_next_s;
      led_red_r       <= (state_next_s == S_HIT) ? blink_next_s : (state_next_s == S_OVER);
      led_green_r     <= (state_next_s == S_WIN) ? blink_next_s : (state_next_s == S_STAGE_CLR);
    end
  end

  // Message strobe: one cycle after msg_sel changes, and once after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_sel_prev_r <= S_IDLE;
      msg_update_r   <= 1'b0;
      boot_r         <= 1'b1;
    end else begin
      msg_sel_prev_r <= msg_sel_r;
      msg_update_r   <= boot_r || (msg_sel_r != msg_sel_prev_r);
      boot_r         <= 1'b0;
    end
  end

  assign run_game      = run_game_r;
  assign stage_restart = stage_restart_r;
  assign lives         = lives_r;
  assign stage         = stage_r;
  assign score         = score_r;
  assign msg_sel       = msg_sel_r;
  assign msg_update    = msg_update_r;
  assign led_red       = led_red_r;
  assign led_green     = led_green_r;

endmodule

// File: tb/tb_game_event_ctrl.sv
// Directed bench for game_event_ctrl with small timing parameters.
// Outputs are sampled 1 time unit after each rising edge.
module tb_game_event_ctrl;

  logic        clk;
  logic        rst;
  logic        key_star;
  logic        collision_detected;
  logic        game_clear;
  logic        run_game;
  logic        stage_restart;
  logic [3:0]  lives;
  logic [3:0]  stage;
  logic [13:0] score;
  logic [2:0]  msg_sel;
  logic        msg_update;
  logic        led_red;
  logic        led_green;

  int n_cmp;
  int n_bad;
  int restart_cnt;

  game_event_ctrl #(
    .TICK_DIV(4), .NUM_LIVES(2), .NUM_STAGES(2),
    .HIT_PAUSE_TICKS(3), .BLINK_TICKS(2), .SCORE_W(14)
  ) dut (
    .clk(clk), .rst(rst), .key_star(key_star),
    .collision_detected(collision_detected), .game_clear(game_clear),
    .run_game(run_game), .stage_restart(stage_restart),
    .lives(lives), .stage(stage), .score(score),
    .msg_sel(msg_sel), .msg_update(msg_update),
    .led_red(led_red), .led_green(led_green)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_run"},   32'(run_game), 32'd0);
    chk({tag, "_rst"},   32'(stage_restart), 32'd0);
    chk({tag, "_lives"}, 32'(lives), 32'd2);
    chk({tag, "_stage"}, 32'(stage), 32'd0);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_msg"},   32'(msg_sel), 32'd0);
    chk({tag, "_upd"},   32'(msg_update), 32'd0);
    chk({tag, "_red"},   32'(led_red), 32'd0);
    chk({tag, "_grn"},   32'(led_green), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    key_star = 1'b0;
    collision_detected = 1'b0;
    game_clear = 1'b0;
    step(3);
    chk_reset_vals("reset");

    // Release reset: one boot strobe on msg_update.
    rst = 1'b0;
    step(1);
    chk("boot_upd", 32'(msg_update), 32'd1);
    step(1);
    chk("boot_upd_off", 32'(msg_update), 32'd0);

    // Start: key held 5 cycles gives exactly one restart pulse.
    key_star = 1'b1;
    restart_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (stage_restart) restart_cnt++;
      if (i == 0) begin
        chk("start_run", 32'(run_game), 32'd1);
        chk("start_msg", 32'(msg_sel), 32'd1);
        chk("start_lives", 32'(lives), 32'd2);
      end
      if (i == 1) chk("start_upd", 32'(msg_update), 32'd1);
    end
    key_star = 1'b0;
    chk("start_restarts", 32'(restart_cnt), 32'd1);
    step(3);
    chk("score_7cyc", 32'(score), 32'd1);
    step(1);
    chk("score_8cyc", 32'(score), 32'd2);

    // Hit with lives=2; inputs ignored during the pause.
    collision_detected = 1'b1;
    step(1);
    collision_detected = 1'b0;
    chk("hit_run", 32'(run_game), 32'd0);
    chk("hit_lives", 32'(lives), 32'd1);
    chk("hit_msg", 32'(msg_sel), 32'd2);
    chk("hit_red", 32'(led_red), 32'd1);
    step(1);
    collision_detected = 1'b1;
    game_clear = 1'b1;
    key_star = 1'b1;
    step(5);
    collision_detected = 1'b0;
    game_clear = 1'b0;
    key_star = 1'b0;
    step(1);
    chk("hit_ignore_lives", 32'(lives), 32'd1);
    chk("hit_red_7", 32'(led_red), 32'd1);
    chk("hit_score", 32'(score), 32'd2);
    step(1);
    chk("hit_red_8", 32'(led_red), 32'd0);
    step(3);
    chk("hit_still_paused", 32'(run_game), 32'd0);
    step(1);
    chk("resume_run", 32'(run_game), 32'd1);
    chk("resume_restart", 32'(stage_restart), 32'd1);
    chk("resume_msg", 32'(msg_sel), 32'd1);
    chk("resume_score", 32'(score), 32'd2);
    step(1);
    chk("resume_restart_off", 32'(stage_restart), 32'd0);

    // Fatal hit -> OVER, then back to IDLE and restart.
    collision_detected = 1'b1;
    step(1);
    collision_detected = 1'b0;
    chk("over_lives", 32'(lives), 32'd0);
    chk("over_msg", 32'(msg_sel), 32'd4);
    step(3);
    chk("over_red", 32'(led_red), 32'd1);
    key_star = 1'b1;
    step(1);
    key_star = 1'b0;
    chk("idle_msg", 32'(msg_sel), 32'd0);
    chk("idle_lives_kept", 32'(lives), 32'd0);
    chk("idle_red", 32'(led_red), 32'd0);
    step(1);
    chk("idle_upd", 32'(msg_update), 32'd1);
    key_star = 1'b1;
    step(1);
    key_star = 1'b0;
    chk("restart_lives", 32'(lives), 32'd2);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_pulse", 32'(stage_restart), 32'd1);

    // Simultaneous collision and clear: collision wins.
    collision_detected = 1'b1;
    game_clear = 1'b1;
    step(1);
    collision_detected = 1'b0;
    game_clear = 1'b0;
    chk("simul_msg", 32'(msg_sel), 32'd2);
    chk("simul_stage", 32'(stage), 32'd0);
    chk("simul_lives", 32'(lives), 32'd1);
    step(12);
    chk("simul_resume", 32'(run_game), 32'd1);

    // Stage clear, next stage, then win with blinking green.
    game_clear = 1'b1;
    step(1);
    game_clear = 1'b0;
    chk("clr_msg", 32'(msg_sel), 32'd3);
    chk("clr_green", 32'(led_green), 32'd1);
    chk("clr_run", 32'(run_game), 32'd0);
    key_star = 1'b1;
    step(1);
    key_star = 1'b0;
    chk("stage1_stage", 32'(stage), 32'd1);
    chk("stage1_run", 32'(run_game), 32'd1);
    chk("stage1_green", 32'(led_green), 32'd0);
    game_clear = 1'b1;
    step(1);
    game_clear = 1'b0;
    chk("win_msg", 32'(msg_sel), 32'd5);
    chk("win_green0", 32'(led_green), 32'd1);
    step(7);
    chk("win_green7", 32'(led_green), 32'd1);
    step(1);
    chk("win_green8", 32'(led_green), 32'd0);
    step(7);
    chk("win_green15", 32'(led_green), 32'd0);
    step(1);
    chk("win_green16", 32'(led_green), 32'd1);
    key_star = 1'b1;
    step(1);
    key_star = 1'b0;
    chk("win_idle_msg", 32'(msg_sel), 32'd0);

    // Reset in the middle of a hit pause.
    step(1);
    key_star = 1'b1;
    step(1);
    key_star = 1'b0;
    collision_detected = 1'b1;
    step(1);
    collision_detected = 1'b0;
    chk("mid_hit_msg", 32'(msg_sel), 32'd2);
    step(3);
    rst = 1'b1;
    step(1);
    chk_reset_vals("midrst");
    rst = 1'b0;
    step(1);
    chk("midrst_boot", 32'(msg_update), 32'd1);
    chk("midrst_norestart", 32'(stage_restart), 32'd0);
    step(12);
    chk("midrst_idle_msg", 32'(msg_sel), 32'd0);
    chk("midrst_idle_run", 32'(run_game), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
